stack_driver: RTL and testbench
===============================

Name: stack_driver

Overview:
- Initiator side of the 8-bit operand stack interface used by the multicycle CPU.
- Accepts one stack-machine opcode at a time over a valid/ready handshake.
- Sequences the single-cycle push/pop/tos strobes the stack responds to, and captures popped data.
- Performs binary ALU ops on the top two entries, tracks occupancy, and flags overflow/underflow before any strobe is issued.

Parameters:
DW, 8, data width of stack entries and op_data/res_data.
DEPTH, 32, stack capacity in entries; must match the attached stack.
CW, $clog2(DEPTH+1), width of the occupancy counter (derived, not overridden).

Ports:
clk  in  1  clock.
rst  in  1  synchronous active-high reset; shared with the attached stack.
op_valid  in  1  opcode request valid.
op_code  in  3  0 NOP, 1 PUSH, 2 POP, 3 TOS, 4 ADD, 5 SUB, 6 AND, 7 DUP.
op_data  in  DW  immediate for PUSH; ignored otherwise.
op_ready  out  1  high only in IDLE; the transfer is op_valid && op_ready at a clock edge.
stk_din  out  DW  data to stack.
stk_push  out  1  push strobe.
stk_pop  out  1  pop strobe.
stk_tos  out  1  read-top strobe.
stk_dout  in  DW  stack read data.
res_valid  out  1  one-cycle result pulse.
res_data  out  DW  result value; held until the next res_valid.
depth  out  CW  current occupancy, 0..DEPTH.
err_under  out  1  one-cycle pulse: op rejected, insufficient entries.
err_over  out  1  one-cycle pulse: op rejected, stack full.
flag_z  out  1  zero flag (see Optional Feature).
flag_c  out  1  carry/borrow flag (see Optional Feature).

Behaviour:
- All outputs are registered.
- Reset (synchronous, active-high):
  - state IDLE, depth 0.
  - All strobes, res_valid and error pulses 0; res_data 0, stk_din 0, flags 0.
  - op_ready 1 in the first cycle after reset deasserts.
  - Reset mid-sequence abandons the op immediately, with no further strobes.
- Stack contract:
  - Each strobe is asserted for exactly one cycle.
  - stk_dout is valid in the cycle after a pop/tos strobe cycle and is sampled at the end of that cycle.
  - At most one strobe is high in any cycle.
- FSM states: IDLE, PUSH, POP_A, CAP_A, POP_B, CAP_B, TOS_A, PUSH_R.
- Cycle numbering: the accept edge is E0; cycle k follows E0.
- Occupancy checks are performed in IDLE using depth at acceptance:
  - PUSH needs depth<DEPTH.
  - POP and TOS need depth>=1.
  - ADD, SUB and AND need depth>=2.
  - DUP needs 1<=depth<DEPTH.
  - On a failed check: the matching err pulse is high in cycle 1, no strobes are issued, depth is unchanged, the FSM stays in IDLE, and op_ready stays 1.
  - err_under takes precedence if both checks could apply.
- NOP: consumed; no strobe, no res_valid; op_ready stays 1.
- PUSH: cycle 1 stk_push=1, stk_din=op_data; depth+1 at the end of cycle 1; IDLE in cycle 2. No res_valid.
- POP:
  - cycle 1 stk_pop; cycle 2 capture a=stk_dout.
  - cycle 3: IDLE, res_valid=1, res_data=a; depth-1.
- TOS: same timing as POP using stk_tos; depth unchanged.
- ADD, SUB, AND:
  - cycle 1 POP_A, cycle 2 CAP_A (a = top), cycle 3 POP_B, cycle 4 CAP_B (b = next).
  - cycle 5 PUSH_R: stk_push with r = b+a, b-a or b&a, mod 2^DW.
  - cycle 6: IDLE, res_valid=1, res_data=r; net depth-1.
- DUP:
  - cycle 1 TOS_A, cycle 2 CAP_A, cycle 3 PUSH_R (stk_din=a).
  - cycle 4: res_valid=1, res_data=a; depth+1.
- While busy, op_ready=0 and op_valid/op_code/op_data are ignored. The requester must hold them until accepted.
- depth never wraps; the occupancy checks guarantee 0..DEPTH.

Optional Feature:
- Macro: STACK_DRIVER_FLAGS_EN.
- Defined: flag_z and flag_c update in the PUSH_R cycle of ADD, SUB and AND only.
  - flag_z = (r==0).
  - flag_c = carry-out for ADD, borrow (b<a) for SUB, 0 for AND.
  - Flags hold otherwise.
- Undefined: flag_z and flag_c are tied to 0 and no flag logic is synthesized. The ports remain present.

Decomposition:
- Package stack_driver_pkg holds:
  - the opcode enum (3-bit) and FSM state enum;
  - the DW default;
  - the opcode-class helper constants (operands required, net depth delta).
- Sub-module stack_driver_alu: combinational; inputs a, b, op; outputs r, carry.

Test Plan:
- Reset, then PUSH 0x05, PUSH 0x03, SUB -> strobe sequence pop,-,pop,-,push with stk_din=0x02; res_data=0x02 in cycle 6; depth=1.
- PUSH 0xFF, PUSH 0x01, ADD -> r=0x00; with STACK_DRIVER_FLAGS_EN, flag_z=1 and flag_c=1; without the macro both flags are 0.
- POP with depth 0 -> err_under pulse in cycle 1, no strobes, op_ready stays 1, depth stays 0.
- 32 PUSHes of values 0..31, then PUSH 0xAA -> err_over pulse, no stk_push; DUP also gives err_over; then TOS -> res_data=0x1F, depth=32.
- PUSH 0x7E, DUP, POP, POP -> res_data 0x7E on each; depth returns to 0.
- Assert rst during CAP_B of an ADD -> next cycle all strobes 0, depth=0, op_ready=1; a following POP gives err_under.

Source files
------------

// File: rtl/stack_driver_pkg.sv
// stack_driver_pkg: shared types and opcode-class helpers for stack_driver.
//   op_e        - 3-bit stack-machine opcode encoding
//   state_e     - sequencing FSM states
//   DW_DEF      - default data width
//   need_ops    - entries an opcode must find on the stack
//   depth_delta - net occupancy change of a completed opcode
package stack_driver_pkg;

    localparam int DW_DEF = 8;

    typedef enum logic [2:0] {
        OP_NOP  = 3'd0,
        OP_PUSH = 3'd1,
        OP_POP  = 3'd2,
        OP_TOS  = 3'd3,
        OP_ADD  = 3'd4,
        OP_SUB  = 3'd5,
        OP_AND  = 3'd6,
        OP_DUP  = 3'd7
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PUSH,
        ST_POP_A,
        ST_CAP_A,
        ST_POP_B,
        ST_CAP_B,
        ST_TOS_A,
        ST_PUSH_R
    } state_e;

    function automatic logic is_alu(op_e op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND);
    endfunction

    function automatic logic [1:0] need_ops(op_e op);
        case (op)
            OP_POP, OP_TOS, OP_DUP: return 2'd1;
            OP_ADD, OP_SUB, OP_AND: return 2'd2;
            default:                return 2'd0;
        endcase
    endfunction

    function automatic logic signed [1:0] depth_delta(op_e op);
        case (op)
            OP_PUSH, OP_DUP:                return 2'sd1;
            OP_POP, OP_ADD, OP_SUB, OP_AND: return -2'sd1;
            default:                        return 2'sd0;
        endcase
    endfunction

endpackage

// File: rtl/stack_driver_alu.sv
// stack_driver_alu: combinational binary op on the two popped entries.
//   a     - first popped entry (old top)
//   b     - second popped entry
//   op    - opcode; only ADD/SUB/AND produce a result
//   r     - b+a, b-a or b&a, modulo 2^DW
//   carry - carry-out for ADD, borrow (b<a) for SUB, 0 otherwise
module stack_driver_alu
    import stack_driver_pkg::*;
#(
    parameter int DW = DW_DEF
) (
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    input  op_e           op,
    output logic [DW-1:0] r,
    output logic          carry
);

    always_comb begin
        r     = '0;
        carry = 1'b0;
        case (op)
            OP_ADD:  {carry, r} = {1'b0, b} + {1'b0, a};
            // The extra top bit of a DW+1 wide difference is set exactly when b < a.
            OP_SUB:  {carry, r} = {1'b0, b} - {1'b0, a};
            OP_AND:  r = b & a;
            default: ;
        endcase
    end

endmodule

// File: rtl/stack_driver.sv
// stack_driver: initiator for the 8-bit operand stack. Accepts one opcode per
// valid/ready handshake, issues one-cycle push/pop/tos strobes, captures
// popped data, runs ADD/SUB/AND on the top two entries and tracks occupancy.
//   clk, rst              - clock, synchronous active-high reset
//   op_valid/op_ready     - opcode handshake (ready only while idle)
//   op_code, op_data      - opcode and PUSH immediate
//   stk_din/push/pop/tos  - stack strobes and write data
//   stk_dout              - stack read data, valid the cycle after pop/tos
//   res_valid, res_data   - result pulse and held result
//   depth                 - occupancy 0..DEPTH
//   err_under, err_over   - rejected-op pulses
//   flag_z, flag_c        - ALU flags, only when STACK_DRIVER_FLAGS_EN is defined
module stack_driver
    import stack_driver_pkg::*;
#(
    parameter int DW    = DW_DEF,
    parameter int DEPTH = 32,
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          op_valid,
    input  logic [2:0]    op_code,
    input  logic [DW-1:0] op_data,
    output logic          op_ready,
    output logic [DW-1:0] stk_din,
    output logic          stk_push,
    output logic          stk_pop,
    output logic          stk_tos,
    input  logic [DW-1:0] stk_dout,
    output logic          res_valid,
    output logic [DW-1:0] res_data,
    output logic [CW-1:0] depth,
    output logic          err_under,
    output logic          err_over,
    output logic          flag_z,
    output logic          flag_c
);

    state_e        state_q, state_d;
    op_e           op_q, op_d, op_in;
    logic [DW-1:0] a_q, a_d, alu_r;
    logic          alu_c, accept, under, over;
    logic          push_d, pop_d, tos_d, rv_d, eu_d, eo_d;
    logic [DW-1:0] din_d, rd_d;
    logic [CW-1:0] depth_d;

    assign op_in  = op_e'(op_code);
    assign accept = op_valid && op_ready;
    assign under  = depth < CW'(need_ops(op_in));
    assign over   = (depth_delta(op_in) == 2'sd1) && (depth == CW'(DEPTH));

    stack_driver_alu #(.DW(DW)) u_alu (
        .a     (a_q),
        .b     (stk_dout),
        .op    (op_q),
        .r     (alu_r),
        .carry (alu_c)
    );

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            op_q      <= OP_NOP;
            a_q       <= '0;
            op_ready  <= 1'b1;
            stk_din   <= '0;
            stk_push  <= 1'b0;
            stk_pop   <= 1'b0;
            stk_tos   <= 1'b0;
            res_valid <= 1'b0;
            res_data  <= '0;
            depth     <= '0;
            err_under <= 1'b0;
            err_over  <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            a_q       <= a_d;
            op_ready  <= (state_d == ST_IDLE);
            stk_din   <= din_d;
            stk_push  <= push_d;
            stk_pop   <= pop_d;
            stk_tos   <= tos_d;
            res_valid <= rv_d;
            res_data  <= rd_d;
            depth     <= depth_d;
            err_under <= eu_d;
            err_over  <= eo_d;
        end
    end

    // Next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:
                if (accept && !under && !over) begin
                    case (op_in)
                        OP_PUSH:                        state_d = ST_PUSH;
                        OP_POP, OP_ADD, OP_SUB, OP_AND: state_d = ST_POP_A;
                        OP_TOS, OP_DUP:                 state_d = ST_TOS_A;
                        default:                        state_d = ST_IDLE;
                    endcase
                end
            ST_PUSH:  state_d = ST_IDLE;
            ST_POP_A: state_d = ST_CAP_A;
            ST_TOS_A: state_d = ST_CAP_A;
            ST_CAP_A:
                if (is_alu(op_q))         state_d = ST_POP_B;
                else if (op_q == OP_DUP)  state_d = ST_PUSH_R;
                else                      state_d = ST_IDLE;
            ST_POP_B:  state_d = ST_CAP_B;
            ST_CAP_B:  state_d = ST_PUSH_R;
            ST_PUSH_R: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Next values of the registered outputs. A strobe is set on the edge that
    // enters the state in which it must be high.
    always_comb begin
        op_d    = op_q;
        a_d     = a_q;
        push_d  = 1'b0;
        pop_d   = 1'b0;
        tos_d   = 1'b0;
        rv_d    = 1'b0;
        eu_d    = 1'b0;
        eo_d    = 1'b0;
        din_d   = stk_din;
        rd_d    = res_data;
        depth_d = depth;
        case (state_q)
            ST_IDLE:
                if (accept) begin
                    op_d = op_in;
                    if (under)     eu_d = 1'b1;
                    else if (over) eo_d = 1'b1;
                    else begin
                        case (op_in)
                            OP_PUSH: begin
                                push_d = 1'b1;
                                din_d  = op_data;
                            end
                            OP_POP, OP_ADD, OP_SUB, OP_AND: pop_d = 1'b1;
                            OP_TOS, OP_DUP:                 tos_d = 1'b1;
                            default: ;
                        endcase
                    end
                end
            ST_CAP_A: begin
                a_d = stk_dout;
                if (is_alu(op_q)) pop_d = 1'b1;
                else if (op_q == OP_DUP) begin
                    push_d = 1'b1;
                    din_d  = stk_dout;
                end else begin
                    rv_d = 1'b1;
                    rd_d = stk_dout;
                end
            end
            ST_CAP_B: begin
                push_d = 1'b1;
                din_d  = alu_r;
            end
            // stk_din still holds whatever was just pushed (r, or a for DUP).
            ST_PUSH_R: begin
                rv_d = 1'b1;
                rd_d = stk_din;
            end
            default: ;
        endcase
        // Occupancy moves once, on the edge that returns to idle.
        if (state_q != ST_IDLE && state_d == ST_IDLE)
            depth_d = depth + CW'(depth_delta(op_q));
    end

`ifdef STACK_DRIVER_FLAGS_EN
    // Flags latch on the edge into PUSH_R, from the result being pushed.
    always_ff @(posedge clk) begin
        if (rst) begin
            flag_z <= 1'b0;
            flag_c <= 1'b0;
        end else if (state_q == ST_CAP_B) begin
            flag_z <= (alu_r == '0);
            flag_c <= alu_c;
        end
    end
`else
    logic unused_carry;
    assign unused_carry = alu_c;
    assign flag_z = 1'b0;
    assign flag_c = 1'b0;
`endif

endmodule

// File: tb/tb_stack_driver.sv
module tb_stack_driver;
    localparam int DW    = 8;
    localparam int DEPTH = 32;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          op_valid = 1'b0;
    logic [2:0]    op_code = '0;
    logic [DW-1:0] op_data = '0;
    logic          op_ready;
    logic [DW-1:0] stk_din;
    logic          stk_push, stk_pop, stk_tos;
    logic [DW-1:0] stk_dout = '0;
    logic          res_valid;
    logic [DW-1:0] res_data;
    logic [CW-1:0] depth;
    logic          err_under, err_over, flag_z, flag_c;

    int errors = 0;
    int checks = 0;

    stack_driver #(.DW(DW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .op_valid(op_valid), .op_code(op_code), .op_data(op_data),
        .op_ready(op_ready), .stk_din(stk_din), .stk_push(stk_push), .stk_pop(stk_pop),
        .stk_tos(stk_tos), .stk_dout(stk_dout), .res_valid(res_valid), .res_data(res_data),
        .depth(depth), .err_under(err_under), .err_over(err_over),
        .flag_z(flag_z), .flag_c(flag_c)
    );

    always #5 clk = ~clk;

    // Attached stack: registered read data, shares rst.
    logic [DW-1:0] mem [DEPTH];
    int sp = 0;
    always @(posedge clk) begin
        if (rst) sp <= 0;
        else if (stk_push) begin
            if (sp < DEPTH) mem[sp] <= stk_din;
            sp <= sp + 1;
        end else if (stk_pop) begin
            if (sp > 0) stk_dout <= mem[sp-1];
            sp <= sp - 1;
        end else if (stk_tos) begin
            if (sp > 0) stk_dout <= mem[sp-1];
        end
    end

    typedef struct {
        logic       eu;
        logic       eo;
        int         nerr;
        int         res_cyc;
        int         nres;
        logic [7:0] res;
        logic [19:0] pat;   // per cycle: 0 none, 1 push, 2 pop, 3 tos
        int         done;
        logic [7:0] din;
        int         multi;
    } obs_t;

    // Reference model: a queue of entries, back = top.
    logic [7:0] q[$];
    bit mz = 0, mc = 0;

    task automatic model_op(input logic [2:0] code, input logic [7:0] data, output obs_t e);
        int need, a, b, s;
        e = '{default: 0};
        need = (code == 2 || code == 3 || code == 7) ? 1 : (code >= 4 && code <= 6) ? 2 : 0;
        if (code == 0) e.done = 1;
        else if (q.size() < need) begin e.eu = 1; e.nerr = 1; e.done = 1; end
        else if ((code == 1 || code == 7) && q.size() == DEPTH) begin e.eo = 1; e.nerr = 1; e.done = 1; end
        else begin
            case (code)
                1: begin q.push_back(data); e.pat = 20'h1; e.done = 2; e.din = data; end
                2: begin e.res = q.pop_back(); e.res_cyc = 3; e.nres = 1; e.done = 3; e.pat = 20'h2; end
                3: begin e.res = q[$]; e.res_cyc = 3; e.nres = 1; e.done = 3; e.pat = 20'h3; end
                7: begin
                    e.res = q[$]; q.push_back(e.res); e.din = e.res;
                    e.pat = 20'h013; e.res_cyc = 4; e.nres = 1; e.done = 4;
                end
                default: begin
                    a = q.pop_back(); b = q.pop_back();
                    if (code == 4) begin s = b + a; mc = (s > 255); end
                    else if (code == 5) begin s = b - a; mc = (b < a); end
                    else begin s = b & a; mc = 0; end
                    s = s & 255; mz = (s == 0);
                    q.push_back(8'(s));
                    e.res = 8'(s); e.din = 8'(s); e.pat = 20'h122;
                    e.res_cyc = 6; e.nres = 1; e.done = 6;
                end
            endcase
        end
    endtask

    function automatic logic exp_fz();
`ifdef STACK_DRIVER_FLAGS_EN
        return mz;
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic exp_fc();
`ifdef STACK_DRIVER_FLAGS_EN
        return mc;
`else
        return 1'b0;
`endif
    endfunction

    // Drives one opcode and records what the DUT did in cycles 1..10.
    // Returns at the negedge of the first cycle where op_ready is high again.
    task automatic run_op(input logic [2:0] code, input logic [7:0] data, output obs_t o);
        int w = 0;
        o = '{default: 0};
        while (!op_ready && w < 20) begin @(negedge clk); w++; end
        op_valid = 1'b1; op_code = code; op_data = data;
        @(negedge clk);
        op_valid = 1'b0; op_code = 3'($urandom); op_data = 8'($urandom);
        for (int c = 1; c <= 10; c++) begin
            if (c > 1) @(negedge clk);
            if (int'(stk_push) + int'(stk_pop) + int'(stk_tos) > 1) o.multi++;
            if (stk_push) begin o.pat[2*(c-1) +: 2] = 2'd1; o.din = stk_din; end
            if (stk_pop)  o.pat[2*(c-1) +: 2] = 2'd2;
            if (stk_tos)  o.pat[2*(c-1) +: 2] = 2'd3;
            if (err_under || err_over) o.nerr++;
            if (c == 1) begin o.eu = err_under; o.eo = err_over; end
            if (res_valid) begin o.res_cyc = c; o.res = res_data; o.nres++; end
            if (op_ready) begin o.done = c; break; end
        end
    endtask

    task automatic step(input logic [2:0] code, input logic [7:0] data, output obs_t o, output obs_t e);
        model_op(code, data, e);
        run_op(code, data, o);
    endtask

    task automatic test_reset();
        checks++;
        if (op_ready !== 1'b1 || depth !== '0 || stk_push !== 0 || stk_pop !== 0 || stk_tos !== 0) begin
            errors++; $display("FAIL reset_ctrl: ready=%b depth=%0d strobes=%b%b%b, want 1 0 000",
                               op_ready, depth, stk_push, stk_pop, stk_tos);
        end
        checks++;
        if (res_valid !== 0 || res_data !== '0 || stk_din !== '0 || err_under !== 0 || err_over !== 0
            || flag_z !== 0 || flag_c !== 0) begin
            errors++; $display("FAIL reset_data: rv=%b rd=%h din=%h eu=%b eo=%b z=%b c=%b, want all 0",
                               res_valid, res_data, stk_din, err_under, err_over, flag_z, flag_c);
        end
    endtask

    task automatic test_sub();
        obs_t o, e;
        step(1, 8'h05, o, e);
        step(1, 8'h03, o, e);
        step(5, 8'h00, o, e);
        checks++;
        if (o.pat !== 20'h122 || o.din !== 8'h02 || o.multi != 0) begin
            errors++; $display("FAIL sub_strobes: pat=%h din=%h multi=%0d, want 00122 02 0", o.pat, o.din, o.multi);
        end
        checks++;
        if (o.res_cyc != 6 || o.res !== 8'h02 || o.done != 6) begin
            errors++; $display("FAIL sub_result: cyc=%0d res=%h done=%0d, want 6 02 6", o.res_cyc, o.res, o.done);
        end
        checks++;
        if (depth !== CW'(1)) begin errors++; $display("FAIL sub_depth: got %0d want 1", depth); end
        step(2, 8'h00, o, e);
    endtask

    task automatic test_add_flags();
        obs_t o, e;
        logic ez, ec;
        step(1, 8'hFF, o, e);
        step(1, 8'h01, o, e);
        step(4, 8'h00, o, e);
`ifdef STACK_DRIVER_FLAGS_EN
        ez = 1'b1; ec = 1'b1;
`else
        ez = 1'b0; ec = 1'b0;
`endif
        checks++;
        if (o.res !== 8'h00 || o.res_cyc != 6) begin
            errors++; $display("FAIL add_result: res=%h cyc=%0d, want 00 6", o.res, o.res_cyc);
        end
        checks++;
        if (flag_z !== ez || flag_c !== ec) begin
            errors++; $display("FAIL add_flags: z=%b c=%b, want %b %b", flag_z, flag_c, ez, ec);
        end
        step(2, 8'h00, o, e);
    endtask

    task automatic test_underflow();
        obs_t o, e;
        step(2, 8'h00, o, e);
        checks++;
        if (o.eu !== 1'b1 || o.eo !== 1'b0 || o.nerr != 1 || o.pat !== '0 || o.done != 1 || depth !== '0) begin
            errors++; $display("FAIL underflow: eu=%b eo=%b nerr=%0d pat=%h done=%0d depth=%0d, want 1 0 1 0 1 0",
                               o.eu, o.eo, o.nerr, o.pat, o.done, depth);
        end
    endtask

    task automatic test_overflow();
        obs_t o, e;
        for (int i = 0; i < DEPTH; i++) step(1, 8'(i), o, e);
        checks++;
        if (depth !== CW'(DEPTH)) begin errors++; $display("FAIL full_depth: got %0d want %0d", depth, DEPTH); end
        step(1, 8'hAA, o, e);
        checks++;
        if (o.eo !== 1'b1 || o.eu !== 1'b0 || o.pat !== '0 || o.done != 1) begin
            errors++; $display("FAIL over_push: eo=%b eu=%b pat=%h done=%0d, want 1 0 0 1", o.eo, o.eu, o.pat, o.done);
        end
        step(7, 8'h00, o, e);
        checks++;
        if (o.eo !== 1'b1 || o.pat !== '0) begin
            errors++; $display("FAIL over_dup: eo=%b pat=%h, want 1 0", o.eo, o.pat);
        end
        step(3, 8'h00, o, e);
        checks++;
        if (o.res !== 8'h1F || o.res_cyc != 3 || o.pat !== 20'h3 || depth !== CW'(DEPTH)) begin
            errors++; $display("FAIL full_tos: res=%h cyc=%0d pat=%h depth=%0d, want 1f 3 3 %0d",
                               o.res, o.res_cyc, o.pat, depth, DEPTH);
        end
        for (int i = 0; i < DEPTH; i++) begin
            step(2, 8'h00, o, e);
            checks++;
            if (o.res !== e.res) begin errors++; $display("FAIL drain_pop: got %h want %h", o.res, e.res); end
        end
    endtask

    task automatic test_dup();
        obs_t o, e;
        step(1, 8'h7E, o, e);
        step(7, 8'h00, o, e);
        checks++;
        if (o.res !== 8'h7E || o.res_cyc != 4 || o.pat !== 20'h013 || o.din !== 8'h7E || depth !== CW'(2)) begin
            errors++; $display("FAIL dup: res=%h cyc=%0d pat=%h din=%h depth=%0d, want 7e 4 013 7e 2",
                               o.res, o.res_cyc, o.pat, o.din, depth);
        end
        for (int i = 0; i < 2; i++) begin
            step(2, 8'h00, o, e);
            checks++;
            if (o.res !== 8'h7E) begin errors++; $display("FAIL dup_pop: got %h want 7e", o.res); end
        end
        checks++;
        if (depth !== '0) begin errors++; $display("FAIL dup_depth: got %0d want 0", depth); end
    endtask

    task automatic test_random(input int n, input int push_w);
        obs_t o, e;
        logic [2:0] code;
        for (int i = 0; i < n; i++) begin
            int r = $urandom_range(0, 9 + push_w);
            if (r == 0) code = 3'd0;
            else if (r <= 7) code = 3'(r);
            else code = 3'd1;
            step(code, 8'($urandom), o, e);
            checks++;
            if (o.eu !== e.eu || o.eo !== e.eo || o.nerr != e.nerr || o.pat !== e.pat || o.multi != 0) begin
                errors++; $display("FAIL rnd_seq op=%0d: eu=%b eo=%b nerr=%0d pat=%h multi=%0d, want %b %b %0d %h 0",
                                   code, o.eu, o.eo, o.nerr, o.pat, o.multi, e.eu, e.eo, e.nerr, e.pat);
            end
            checks++;
            if (o.done != e.done || o.nres != e.nres || o.res_cyc != e.res_cyc
                || (e.nres != 0 && o.res !== e.res) || (e.pat != 0 && code != 2 && code != 3 && o.din !== e.din)) begin
                errors++; $display("FAIL rnd_res op=%0d: done=%0d nres=%0d cyc=%0d res=%h din=%h, want %0d %0d %0d %h %h",
                                   code, o.done, o.nres, o.res_cyc, o.res, o.din, e.done, e.nres, e.res_cyc, e.res, e.din);
            end
            checks++;
            if (depth !== CW'(q.size()) || flag_z !== exp_fz() || flag_c !== exp_fc()) begin
                errors++; $display("FAIL rnd_state op=%0d: depth=%0d z=%b c=%b, want %0d %b %b",
                                   code, depth, flag_z, flag_c, q.size(), exp_fz(), exp_fc());
            end
        end
    endtask

    task automatic test_reset_mid();
        obs_t o, e;
        step(1, 8'h11, o, e);
        step(1, 8'h22, o, e);
        op_valid = 1'b1; op_code = 3'd4; op_data = 8'h00;
        @(negedge clk);          // cycle 1
        op_valid = 1'b0;
        repeat (3) @(negedge clk); // cycle 4 = CAP_B
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (stk_push !== 0 || stk_pop !== 0 || stk_tos !== 0 || depth !== '0 || op_ready !== 1'b1 || res_valid !== 0) begin
            errors++; $display("FAIL mid_reset: strobes=%b%b%b depth=%0d ready=%b rv=%b, want 000 0 1 0",
                               stk_push, stk_pop, stk_tos, depth, op_ready, res_valid);
        end
        rst = 1'b0;
        q.delete(); mz = 0; mc = 0;
        step(2, 8'h00, o, e);
        checks++;
        if (o.eu !== 1'b1 || o.pat !== '0) begin
            errors++; $display("FAIL mid_reset_pop: eu=%b pat=%h, want 1 0", o.eu, o.pat);
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        test_reset();
        test_sub();
        test_add_flags();
        test_underflow();
        test_overflow();
        test_dup();
        test_random(200, 6);
        test_random(200, 0);
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1);
    end
endmodule
